// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them one at a time and returns results with timeout abort
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_a,
  input  logic [7:0]               push_b,
  input  logic [1:0]               push_op,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     start,
  output logic [7:0]               a,
  output logic [7:0]               b,
  output logic [1:0]               op,
  input  logic [2:0]               alu_state,
  input  logic [15:0]              alu_result,
  output logic                     res_valid,
  output logic [15:0]              res_data,
  output logic [1:0]               res_op,
  output logic                     res_err,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state;
  logic [17:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt_nxt;
  logic [TW-1:0] tmr;
  logic alu_idle, expired, done, abort, pop, put;
  assign alu_idle = alu_state == 3'b000;
  assign expired = tmr >= TW'(TIMEOUT - 1);
  assign done = state == BUSY && alu_idle;
  // ISSUE stalls while the ALU is still idle; BUSY stalls while it is not
  assign abort = expired && ((state == ISSUE && alu_idle) || (state == BUSY && !alu_idle));
  assign pop = done || abort;
  assign put = push && !full;
  assign cnt_nxt = count + (AW+1)'(put) - (AW+1)'(pop);
  always_ff @(posedge clk) begin
    if (put) mem[wr_ptr] <= {push_op, push_a, push_b};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      overflow <= 1'b0;
      start <= 1'b0;
      a <= '0;
      b <= '0;
      op <= '0;
      tmr <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_op <= '0;
      res_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (put) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      full <= cnt_nxt == (AW+1)'(DEPTH);
      if (push && full) overflow <= 1'b1;
      res_valid <= 1'b0;
      if (pop) begin
        state <= IDLE;
        start <= 1'b0;
        busy <= 1'b0;
        res_valid <= 1'b1;
        res_op <= op;
        res_err <= !done;
        res_data <= done ? alu_result : '0;
      end else begin
        case (state)
          IDLE: if (count != '0 && alu_idle) begin
            {op, a, b} <= mem[rd_ptr];
            start <= 1'b1;
            busy <= 1'b1;
            tmr <= '0;
            state <= ISSUE;
          end
          ISSUE: begin
            tmr <= tmr + 1'b1;
            if (!alu_idle) begin
              start <= 1'b0;
              state <= BUSY;
            end
          end
          BUSY: tmr <= tmr + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed checks of the command issuer against a small behavioural ALU
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 20;
  logic clk = 0, rst = 0, push = 0;
  logic [7:0] push_a = 0, push_b = 0;
  logic [1:0] push_op = 0;
  logic full, overflow, start, res_valid, res_err, busy;
  logic [2:0] count;
  logic [7:0] a, b;
  logic [1:0] op, res_op;
  logic [15:0] res_data;
  logic [2:0] alu_state = 0;
  logic [15:0] alu_result = 0;
  logic force_en = 0, stuck = 0;
  logic [2:0] force_val = 0;
  int mul_cnt = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, starts = 0;
  logic start_q = 0;
  int rv_cyc[$];
  logic [18:0] rv_dat[$];

  alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .push(push), .push_a(push_a), .push_b(push_b), .push_op(push_op),
    .full(full), .count(count), .overflow(overflow), .start(start), .a(a), .b(b), .op(op),
    .alu_state(alu_state), .alu_result(alu_result), .res_valid(res_valid), .res_data(res_data),
    .res_op(res_op), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU: ADD/SUB one non-idle cycle, MUL ten cycles in 011 then one in 101, stuck mode parks in 100
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (force_en) alu_state <= force_val;
    else case (alu_state)
      3'd0: if (start) begin
        alu_result <= op == 2'b00 ? 16'(a) + 16'(b) : op == 2'b01 ? 16'(a) - 16'(b)
                    : 16'({{8{a[7]}}, a} * {{8{b[7]}}, b});
        alu_state <= stuck ? 3'd4 : op == 2'b10 ? 3'd3 : op == 2'b00 ? 3'd1 : 3'd2;
        mul_cnt <= 9;
      end
      3'd3: if (mul_cnt == 0) alu_state <= 3'd5; else mul_cnt <= mul_cnt - 1;
      3'd4: if (!stuck) alu_state <= 3'd0;
      default: alu_state <= 3'd0;
    endcase
  end

  always @(negedge clk) begin
    start_q <= start;
    if (start && !start_q) starts <= starts + 1;
    if (rst && res_valid) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back({res_err, res_op, res_data});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic psh(input logic [7:0] pa, input logic [7:0] pb, input logic [1:0] po);
    push = 1; push_a = pa; push_b = pb; push_op = po;
    step(1);
    push = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bq, bs, k;
    logic stable;
    step(2);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_ab", {a, b, op}, 0);
    chk("rst_res", {res_err, res_op, res_data}, 0);
    rst = 1;
    step(1);
    // single ADD
    psh(8'h05, 8'h03, 2'b00);
    chk("add_count1", count, 1);
    chk("add_start0", start, 0);
    step(1);
    chk("add_start_e0", start, 1);
    chk("add_ops", {a, b, op}, {8'h05, 8'h03, 2'b00});
    chk("add_busy", busy, 1);
    step(1);
    chk("add_start_e1", start, 1);
    step(1);
    chk("add_start_e2", start, 0);
    step(1);
    chk("add_rv", res_valid, 1);
    chk("add_res", {res_err, res_op, res_data}, {1'b0, 2'b00, 16'h0008});
    chk("add_count0", count, 0);
    step(1);
    chk("add_rv_drop", res_valid, 0);
    chk("add_res_hold", res_data, 16'h0008);
    // back-to-back
    bq = rv_cyc.size();
    bs = starts;
    psh(8'd1, 8'd2, 2'b00);
    psh(8'd9, 8'd4, 2'b01);
    psh(8'd7, 8'd7, 2'b00);
    chk("b2b_count", count, 3);
    step(14);
    chk("b2b_n", rv_cyc.size() - bq, 3);
    chk("b2b_r0", rv_dat[bq], {1'b0, 2'b00, 16'h0003});
    chk("b2b_r1", rv_dat[bq+1], {1'b0, 2'b01, 16'h0005});
    chk("b2b_r2", rv_dat[bq+2], {1'b0, 2'b00, 16'h000E});
    chk("b2b_gap1", rv_cyc[bq+1] - rv_cyc[bq], 4);
    chk("b2b_gap2", rv_cyc[bq+2] - rv_cyc[bq+1], 4);
    chk("b2b_starts", starts - bs, 3);
    chk("b2b_idle", {busy, count}, 0);
    // MUL with variable latency
    bq = rv_cyc.size();
    psh(8'hFA, 8'h02, 2'b10);
    step(1);
    stable = 1;
    k = 0;
    while (k < 40 && !res_valid) begin
      if (a !== 8'hFA || b !== 8'h02 || op !== 2'b10) stable = 0;
      step(1);
      k++;
    end
    chk("mul_rv", res_valid, 1);
    chk("mul_lat", k, 13);
    chk("mul_stable", stable, 1);
    chk("mul_res", {res_err, res_op, res_data}, {1'b0, 2'b10, 16'hFFF4});
    step(3);
    chk("mul_once", rv_cyc.size() - bq, 1);
    chk("mul_hold_a", a, 8'hFA);
    // full / overflow with ALU held busy
    bq = rv_cyc.size();
    force_val = 3'd6;
    force_en = 1;
    step(1);
    for (int i = 1; i <= 4; i++) psh(8'(i), 8'(i), 2'b00);
    chk("ful_count4", count, 4);
    chk("ful_full", full, 1);
    chk("ful_ovf0", overflow, 0);
    chk("ful_noissue", start, 0);
    psh(8'd5, 8'd5, 2'b00);
    chk("ful_count_drop", count, 4);
    chk("ful_ovf1", overflow, 1);
    force_en = 0;
    step(22);
    chk("ful_drained", count, 0);
    chk("ful_notfull", full, 0);
    chk("ful_ovf_sticky", overflow, 1);
    chk("ful_n", rv_cyc.size() - bq, 4);
    chk("ful_last", rv_dat[bq+3], {1'b0, 2'b00, 16'h0008});
    // timeout abort
    stuck = 1;
    psh(8'h11, 8'h22, 2'b01);
    step(1);
    chk("to_start", start, 1);
    step(19);
    chk("to_not_yet", res_valid, 0);
    chk("to_busy", busy, 1);
    step(1);
    chk("to_rv", res_valid, 1);
    chk("to_res", {res_err, res_op, res_data}, {1'b1, 2'b01, 16'h0000});
    chk("to_popped", count, 0);
    chk("to_idle", {busy, start}, 0);
    stuck = 0;
    step(2);
    // reset mid-operation
    stuck = 1;
    psh(8'd1, 8'd1, 2'b00);
    psh(8'd2, 8'd2, 2'b00);
    psh(8'd3, 8'd3, 2'b00);
    step(2);
    chk("mr_busy", busy, 1);
    chk("mr_count3", count, 3);
    bq = rv_cyc.size();
    #2 rst = 0;
    #1;
    chk("mr_count", count, 0);
    chk("mr_flags", {full, overflow, start, busy, res_valid}, 0);
    chk("mr_ab", {a, b, op}, 0);
    chk("mr_res", {res_err, res_op, res_data}, 0);
    bs = starts;
    stuck = 0;
    step(2);
    rst = 1;
    step(10);
    chk("mr_no_rv", rv_cyc.size() - bq, 0);
    chk("mr_no_start", starts - bs, 0);
    chk("mr_empty", {busy, count}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Command queue and sequencer directly upstream of the ALU top.
- Buffers operand/opcode commands from the host side, issues them one at a time on the ALU start/a/b/op inputs, and tracks completion via the ALU debug state output.
- Captures the 16-bit ALU result and returns it with a valid pulse, tagged with the opcode.
- Guarantees single-issue, operands held stable for the whole operation, and recovery from a hung ALU.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2).
- TIMEOUT, 255, max cycles an issued command may stay outstanding before abort.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  enqueue request, one command per cycle.
- push_a  in  8  operand a for enqueued command.
- push_b  in  8  operand b for enqueued command.
- push_op  in  2  opcode (00 ADD, 01 SUB, 10 MUL, 11 DIV).
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when push arrives while full; cleared only by reset.
- start  out  1  to ALU start.
- a  out  8  to ALU a.
- b  out  8  to ALU b.
- op  out  2  to ALU op.
- alu_state  in  3  from ALU state output; 000 = idle.
- alu_result  in  16  from ALU result.
- res_valid  out  1  one-cycle pulse, result fields valid.
- res_data  out  16  captured result (0 on abort).
- res_op  out  2  opcode of completed command.
- res_err  out  1  qualifies res_valid; 1 = timeout abort.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst low, async): FIFO empty, count=0, full=0, overflow=0, start=0, a=b=0, op=0, res_valid=0, res_data=0, res_op=0, res_err=0, busy=0, FSM=IDLE, timeout counter=0.
- All outputs are registered.
- FIFO:
  - Push accepted when !full, including while a command is outstanding.
  - Push while full is dropped and sets overflow, even if a pop occurs the same cycle.
  - Pop happens only on completion or abort; the head entry stays in the FIFO while it executes.
  - Pointers wrap modulo DEPTH.
  - Simultaneous accepted push and pop leaves count unchanged.
- FSM states:
  - IDLE: if FIFO not empty and alu_state==000, load a/b/op from the head entry, set start=1, clear the timeout counter, go ISSUE. Otherwise stay.
  - ISSUE: hold start=1. When alu_state!=000, ALU has accepted: set start=0, go BUSY. If alu_state stays 000, remain and count.
  - BUSY: start=0. When alu_state==000, set res_data=alu_result, res_op=op, res_err=0, res_valid=1, pop the FIFO, go IDLE.
  - Abort: in ISSUE or BUSY, when the counter reaches TIMEOUT, set start=0, res_data=0, res_op=op, res_err=1, res_valid=1, pop the FIFO, go IDLE.
- a/b/op stay constant from the IDLE->ISSUE edge through the completion edge. They hold their last value afterwards.
- Latency for ADD/SUB, with the ALU going 000->001/010->000:
  - start rises after edge E0.
  - ALU leaves idle at E1.
  - Issuer sees non-idle at E2 and drops start.
  - Issuer sees idle at E3; res_valid is high in the cycle after E3.
- start must never be high at an edge where alu_state==000 after the ALU has already accepted the command: no double issue.
- Next command may issue at the edge after res_valid is set. Back-to-back ADDs complete every 4 cycles.
- MUL/DIV latency is data-dependent; completion is detected purely on return to 000.
- res_valid deasserts the cycle after it pulses. res_data/res_op/res_err hold until the next completion.
- Reset mid-operation discards all queued and outstanding commands. No res_valid is produced for them.

Test Plan:
- Reset: drive rst=0 mid-BUSY with 3 entries queued -> all outputs at reset values, count=0, no res_valid after release.
- Single ADD: push a=8'h05, b=8'h03, op=00 into an idle ALU model -> start high exactly 2 cycles, res_valid in the 4th cycle after start rises, res_data=16'h0008, res_op=00, res_err=0, count back to 0.
- Back-to-back: push ADD(1,2), SUB(9,4), ADD(7,7) on 3 consecutive cycles -> res_valid pulses 4 cycles apart with res_data 0003, 0005, 000E in order, and only one start pulse per command.
- Full/overflow: DEPTH=4, ALU held non-idle, push 5 commands -> count=4, full=1, 5th dropped, overflow=1 and sticky after the queue drains.
- MUL variable latency: ALU model stays in 011 for 10 cycles, then 101, then 000 with alu_result=16'hFFF4 -> single res_valid with res_data=FFF4 and res_op=10; a/b stable throughout.
- Timeout: TIMEOUT=20, ALU stuck at 100 -> after 20 cycles res_valid=1, res_err=1, res_data=0, entry popped, FSM back in IDLE.
